multi_timer: RTL and testbench
==============================

Name: multi_timer

Overview:
- Parametrised successor to the two fixed single-channel timer devices: one bridge-mapped peripheral with NCH independent down-counting timer channels.
- Each channel supports one-shot and auto-reload modes, a per-channel interrupt mask, and sticky, software-clearable pending/overrun status.
- Sits behind the Bridge: the Bridge drives Addr/DataIn/We and muxes DataOut into PrRD.
- IntReq bits feed HWInt directly, one bit per channel.

Parameters:
- NCH, 2, number of timer channels (1..6; each maps to one HWInt bit).
- CNT_W, 32, counter/preset width in bits (8..32; registers read zero-extended to 32 bits).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous reset, active-low: reset==0 at a rising clk edge resets the block.
- Addr  input  32  word address from Bridge. Addr[3:2] selects the register, Addr[6:4] selects the channel, other bits are ignored.
- DataIn  input  32  write data.
- We  input  1  write enable, sampled on the rising edge.
- DataOut  output  32  combinational read data for Addr.
- IntReq  output  NCH  per-channel interrupt request = pending & IM.
- IntAny  output  1  OR of IntReq.

Behaviour:
- Registers per channel, by Addr[3:2]:
  - 0 CTRL, R/W: bit0 En, bits2:1 Mode (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM; other bits read 0.
  - 1 PRESET, R/W, CNT_W bits.
  - 2 COUNT, read-only; writes ignored.
  - 3 STATUS: bit0 PEND, bit1 OVR. Writing 1 to a bit clears it; writing 0 has no effect.
- Channel index >= NCH: reads return 0, writes are ignored.
- Reset (reset==0): every CTRL, PRESET, COUNT and STATUS cleared, every FSM to IDLE. IntReq=0, IntAny=0. Reset wins over a simultaneous We and takes effect mid-count.
- Per-channel FSM: IDLE, LOAD, CNT.
  - IDLE: if En==1, go to LOAD.
  - LOAD: COUNT<=PRESET, go to CNT. If PRESET==0: clear En, go to IDLE, no interrupt.
  - CNT: if En==0, go to IDLE and freeze COUNT. Otherwise COUNT<=COUNT-1. When the decrement yields 0:
    - set PEND; if PEND was already 1, set OVR.
    - Mode 00: clear En, go to IDLE (COUNT holds 0).
    - Mode 01: go to LOAD, so the period is PRESET+1 cycles.
- Timing, write with En=1 at edge e0:
  - e1: COUNT=PRESET.
  - e1+PRESET: COUNT=0 and PEND=1.
  - IntReq is visible combinationally after that edge, with no extra register stage.
- A CTRL write that sets En=1 while the channel is in CNT does not restart the count.
- Clearing En and then setting it again restarts from LOAD.
- A PRESET write while counting affects only the next LOAD.
- Same-cycle collisions:
  - Hardware PEND-set and a software write-1-clear on the same edge: the set wins (PEND=1).
  - A CTRL write clearing En and an expiry on the same edge: the expiry's status update is kept, and the FSM goes to IDLE.
- Channels are fully independent. Simultaneous expiries on several channels set each channel's own PEND.

Test Plan:
- Reset, then read all registers of ch0..ch(NCH-1) -> all 0; IntReq=0, IntAny=0.
- ch0: PRESET=3, CTRL=0x9 (En, one-shot, IM) -> COUNT reads 3,2,1,0 on successive edges; PEND=1 and IntReq[0]=1 four cycles after the CTRL write; CTRL reads 0x8; write STATUS=1 -> IntReq[0]=0.
- ch1: PRESET=2, CTRL=0xB (auto-reload) -> PEND set every 3 cycles. Leave PEND uncleared -> OVR=1 on the second expiry. Write STATUS=3 -> both bits cleared.
- ch0: IM=0 with an expiry -> PEND=1 but IntReq[0]=0. Then set IM=1 -> IntReq[0]=1 immediately.
- Collision: STATUS write-1 to ch1 on the same edge as ch1 expiry -> PEND stays 1. Drive reset=0 mid-count -> COUNT=0, FSM IDLE next cycle.
- PRESET=0 with En=1 -> En clears after LOAD, no PEND. Access to channel index NCH -> reads 0, writes have no effect on any channel.

Source files
------------

// File: rtl/multi_timer.sv
// Bridge-mapped peripheral with NCH independent down-counting timer channels,
// each with one-shot/auto-reload modes, interrupt mask and sticky PEND/OVR status.
module multi_timer #(
    parameter int NCH   = 2,
    parameter int CNT_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [31:0]    Addr,
    input  logic [31:0]    DataIn,
    input  logic           We,
    output logic [31:0]    DataOut,
    output logic [NCH-1:0] IntReq,
    output logic           IntAny
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;
    localparam logic [1:0] MODE_AUTO  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNT
    } state_e;

    logic [1:0] reg_sel;
    logic [2:0] ch_sel;
    logic       unused_bits;

    assign reg_sel     = Addr[3:2];
    assign ch_sel      = Addr[6:4];
    assign unused_bits = ^{Addr[31:7], Addr[1:0], DataIn};

    state_e           state_q  [NCH];
    state_e           state_d  [NCH];
    logic             en_q     [NCH];
    logic             en_d     [NCH];
    logic [1:0]       mode_q   [NCH];
    logic [1:0]       mode_d   [NCH];
    logic             im_q     [NCH];
    logic             im_d     [NCH];
    logic [CNT_W-1:0] preset_q [NCH];
    logic [CNT_W-1:0] preset_d [NCH];
    logic [CNT_W-1:0] count_q  [NCH];
    logic [CNT_W-1:0] count_d  [NCH];
    logic             pend_q   [NCH];
    logic             pend_d   [NCH];
    logic             ovr_q    [NCH];
    logic             ovr_d    [NCH];

    // A channel index >= NCH never matches any c, so those accesses fall through.
    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned (no latches).
        for (int c = 0; c < NCH; c++) begin
            state_d[c]  = state_q[c];
            en_d[c]     = en_q[c];
            mode_d[c]   = mode_q[c];
            im_d[c]     = im_q[c];
            preset_d[c] = preset_q[c];
            count_d[c]  = count_q[c];
            pend_d[c]   = pend_q[c];
            ovr_d[c]    = ovr_q[c];

            if (We && (ch_sel == 3'(c))) begin
                case (reg_sel)
                    REG_CTRL: begin
                        en_d[c]   = DataIn[0];
                        mode_d[c] = DataIn[2:1];
                        im_d[c]   = DataIn[3];
                    end
                    REG_PRESET: preset_d[c] = DataIn[CNT_W-1:0];
                    REG_STATUS: begin
                        if (DataIn[0]) pend_d[c] = 1'b0;
                        if (DataIn[1]) ovr_d[c]  = 1'b0;
                    end
                    default: ;
                endcase
            end

            // Hardware updates come after the software write so a same-edge expiry wins.
            case (state_q[c])
                ST_IDLE: begin
                    if (en_d[c]) state_d[c] = ST_LOAD;
                end
                ST_LOAD: begin
                    if (preset_q[c] == '0) begin
                        en_d[c]    = 1'b0;
                        state_d[c] = ST_IDLE;
                    end else begin
                        count_d[c] = preset_q[c];
                        state_d[c] = ST_CNT;
                    end
                end
                ST_CNT: begin
                    if (!en_q[c]) begin
                        state_d[c] = ST_IDLE;
                    end else begin
                        count_d[c] = count_q[c] - CNT_W'(1);
                        if (count_q[c] == CNT_W'(1)) begin
                            pend_d[c] = 1'b1;
                            if (pend_q[c]) ovr_d[c] = 1'b1;
                            if (mode_q[c] != MODE_AUTO) begin
                                en_d[c]    = 1'b0;
                                state_d[c] = ST_IDLE;
                            end else if (!en_d[c]) begin
                                state_d[c] = ST_IDLE;
                            end else begin
                                state_d[c] = ST_LOAD;
                            end
                        end
                    end
                end
                default: state_d[c] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments; reset is synchronous, so it also overrides a same-edge write.
        if (!reset) begin
            for (int c = 0; c < NCH; c++) begin
                state_q[c]  <= ST_IDLE;
                en_q[c]     <= 1'b0;
                mode_q[c]   <= 2'b00;
                im_q[c]     <= 1'b0;
                preset_q[c] <= '0;
                count_q[c]  <= '0;
                pend_q[c]   <= 1'b0;
                ovr_q[c]    <= 1'b0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                state_q[c]  <= state_d[c];
                en_q[c]     <= en_d[c];
                mode_q[c]   <= mode_d[c];
                im_q[c]     <= im_d[c];
                preset_q[c] <= preset_d[c];
                count_q[c]  <= count_d[c];
                pend_q[c]   <= pend_d[c];
                ovr_q[c]    <= ovr_d[c];
            end
        end
    end

    always_comb begin
        DataOut = '0;
        for (int c = 0; c < NCH; c++) begin
            if (ch_sel == 3'(c)) begin
                case (reg_sel)
                    REG_CTRL:   DataOut = {28'd0, im_q[c], mode_q[c], en_q[c]};
                    REG_PRESET: DataOut = 32'(preset_q[c]);
                    REG_COUNT:  DataOut = 32'(count_q[c]);
                    REG_STATUS: DataOut = {30'd0, ovr_q[c], pend_q[c]};
                    default:    DataOut = '0;
                endcase
            end
        end
    end

    always_comb begin
        IntReq = '0;
        for (int c = 0; c < NCH; c++) begin
            IntReq[c] = pend_q[c] & im_q[c];
        end
        IntAny = |IntReq;
    end

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: expectations go through a scoreboard queue
// and are compared with immediate assertions when the DUT output is sampled.
module tb_multi_timer;

    localparam int NCH   = 2;
    localparam int CNT_W = 32;

    localparam logic [1:0] R_CTRL   = 2'd0;
    localparam logic [1:0] R_PRESET = 2'd1;
    localparam logic [1:0] R_COUNT  = 2'd2;
    localparam logic [1:0] R_STATUS = 2'd3;

    logic           clk = 1'b0;
    logic           reset;
    logic [31:0]    Addr;
    logic [31:0]    DataIn;
    logic           We;
    logic [31:0]    DataOut;
    logic [NCH-1:0] IntReq;
    logic           IntAny;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int       tests_run    = 0;
    int       tests_failed = 0;

    always #10 clk = ~clk;

    multi_timer #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .Addr   (Addr),
        .DataIn (DataIn),
        .We     (We),
        .DataOut(DataOut),
        .IntReq (IntReq),
        .IntAny (IntAny)
    );

    function automatic logic [31:0] mk_addr(input int ch, input logic [1:0] r);
        logic [2:0] chb;
        chb = 3'(ch);
        return {25'd0, chb, r, 2'b00};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input logic [1:0] r, input logic [31:0] data);
        Addr   = mk_addr(ch, r);
        DataIn = data;
        We     = 1'b1;
        tick();
        We     = 1'b0;
    endtask

    task automatic push(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb.push_back(it);
    endtask

    task automatic check(input logic [31:0] observed);
        sb_item_t it;
        tests_run++;
        if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL scoreboard_empty: observed %h required an expectation", observed);
        end else begin
            it = sb.pop_front();
            assert (observed === it.exp) else begin
                tests_failed++;
                $error("FAIL %s: observed %h expected %h", it.tag, observed, it.exp);
            end
        end
    endtask

    task automatic rd(input int ch, input logic [1:0] r, input string tag, input logic [31:0] exp);
        push(tag, exp);
        Addr = mk_addr(ch, r);
        #1;
        check(DataOut);
    endtask

    task automatic chk_irq(input string tag, input logic [NCH-1:0] req, input logic any);
        push({tag, "_intreq"}, 32'(req));
        #1;
        check(32'(IntReq));
        push({tag, "_intany"}, {31'd0, any});
        check({31'd0, IntAny});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "timeout");
    end

    initial begin
        reset  = 1'b0;
        Addr   = '0;
        DataIn = '0;
        We     = 1'b0;
        tick();
        tick();
        // A write while reset is held must be discarded.
        wr(0, R_PRESET, 32'd5);
        rd(0, R_PRESET, "reset_blocks_write", 32'd0);
        reset = 1'b1;
        tick();

        for (int ch = 0; ch < NCH; ch++) begin
            for (int r = 0; r < 4; r++) begin
                rd(ch, 2'(r), $sformatf("reset_ch%0d_reg%0d", ch, r), 32'd0);
            end
        end
        chk_irq("reset", 2'b00, 1'b0);

        // ch0 one-shot, PRESET=3
        wr(0, R_PRESET, 32'd3);
        wr(0, R_CTRL, 32'h9);
        for (int k = 3; k >= 1; k--) begin
            tick();
            rd(0, R_COUNT, $sformatf("oneshot_count_%0d", k), 32'(k));
        end
        tick();
        rd(0, R_COUNT, "oneshot_count_0", 32'd0);
        rd(0, R_STATUS, "oneshot_pend", 32'd1);
        chk_irq("oneshot_expiry", 2'b01, 1'b1);
        rd(0, R_CTRL, "oneshot_en_cleared", 32'h8);
        wr(0, R_STATUS, 32'd1);
        chk_irq("oneshot_cleared", 2'b00, 1'b0);
        rd(0, R_STATUS, "oneshot_status_cleared", 32'd0);

        // ch1 auto-reload, PRESET=2 -> period 3
        wr(1, R_PRESET, 32'd2);
        wr(1, R_CTRL, 32'hB);
        tick(); tick(); tick();
        rd(1, R_STATUS, "auto_first_expiry", 32'd1);
        tick(); tick(); tick();
        rd(1, R_STATUS, "auto_second_expiry_ovr", 32'd3);
        chk_irq("auto_irq", 2'b10, 1'b1);
        wr(1, R_STATUS, 32'd3);
        rd(1, R_STATUS, "auto_status_cleared", 32'd0);
        tick();
        // Write-1-clear lands on the same edge as the next expiry: set wins.
        wr(1, R_STATUS, 32'd1);
        rd(1, R_STATUS, "collision_pend_kept", 32'd1);
        chk_irq("collision_irq", 2'b10, 1'b1);
        wr(1, R_CTRL, 32'h0);
        tick(); tick();
        rd(1, R_COUNT, "auto_stop_frozen", 32'd2);
        rd(1, R_CTRL, "auto_stop_ctrl", 32'd0);
        wr(1, R_STATUS, 32'd3);
        chk_irq("auto_stop_irq", 2'b00, 1'b0);

        // ch0 masked expiry, then unmask
        wr(0, R_CTRL, 32'h1);
        tick(); tick(); tick(); tick();
        rd(0, R_STATUS, "masked_pend", 32'd1);
        chk_irq("masked_irq", 2'b00, 1'b0);
        wr(0, R_CTRL, 32'h8);
        chk_irq("unmasked_irq", 2'b01, 1'b1);
        wr(0, R_STATUS, 32'd1);
        chk_irq("unmasked_cleared", 2'b00, 1'b0);

        // PRESET=0: En clears after LOAD, no PEND
        wr(0, R_PRESET, 32'd0);
        wr(0, R_CTRL, 32'h9);
        tick();
        rd(0, R_CTRL, "zero_preset_en_cleared", 32'h8);
        tick(); tick(); tick();
        rd(0, R_STATUS, "zero_preset_no_pend", 32'd0);
        chk_irq("zero_preset_irq", 2'b00, 1'b0);

        // Channel index NCH is out of range
        wr(NCH, R_PRESET, 32'h55);
        wr(NCH, R_CTRL, 32'h9);
        wr(NCH, R_STATUS, 32'd3);
        tick();
        rd(NCH, R_CTRL, "oor_ctrl", 32'd0);
        rd(NCH, R_PRESET, "oor_preset", 32'd0);
        rd(NCH, R_COUNT, "oor_count", 32'd0);
        rd(NCH, R_STATUS, "oor_status", 32'd0);
        rd(0, R_PRESET, "oor_ch0_preset", 32'd0);
        rd(1, R_PRESET, "oor_ch1_preset", 32'd2);
        rd(0, R_CTRL, "oor_ch0_ctrl", 32'h8);
        rd(1, R_CTRL, "oor_ch1_ctrl", 32'd0);

        // En rewrite mid-count does not restart; reset mid-count clears all
        wr(1, R_PRESET, 32'd10);
        wr(1, R_CTRL, 32'h1);
        tick(); tick(); tick();
        rd(1, R_COUNT, "midcount_8", 32'd8);
        wr(1, R_CTRL, 32'h1);
        rd(1, R_COUNT, "en_rewrite_no_restart", 32'd7);
        reset  = 1'b0;
        Addr   = mk_addr(1, R_CTRL);
        DataIn = 32'h9;
        We     = 1'b1;
        tick();
        We    = 1'b0;
        reset = 1'b1;
        rd(1, R_COUNT, "midreset_count", 32'd0);
        rd(1, R_CTRL, "midreset_ctrl", 32'd0);
        rd(1, R_PRESET, "midreset_preset", 32'd0);
        tick(); tick();
        rd(1, R_COUNT, "midreset_idle", 32'd0);
        chk_irq("midreset_irq", 2'b00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
